// File: rtl/uart_rx_deframer_if.sv
// Byte-side and line-side signals of the UART receive deframer.
// master: the deframer; slave: the downstream Rx FIFO / operand stage.
interface uart_rx_deframer_if #(
  parameter int DATA_WIDTH = 8
);
  logic                  i_rx;
  logic [DATA_WIDTH-1:0] o_data;
  logic                  o_done;
  logic                  o_frame_err;
  logic                  o_parity_err;

  modport master (
    input  i_rx,
    output o_data, o_done, o_frame_err, o_parity_err
  );

  modport slave (
    output i_rx,
    input  o_data, o_done, o_frame_err, o_parity_err
  );
endinterface

// File: rtl/uart_rx_deframer.sv
// 16x-oversampling UART receiver, 8N1 by default.
// Define UART_RX_PARITY_EN to add an even-parity bit between the data and stop bits.
module uart_rx_deframer #(
  parameter int DATA_WIDTH = 8,
  parameter int TICK_DIV   = 326,
  parameter int OVERSAMPLE = 16
) (
  input logic               i_clock,
  input logic               i_reset,
  uart_rx_deframer_if.master bus
);

  localparam int TW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam int SW = $clog2(OVERSAMPLE);
  localparam int NW = (DATA_WIDTH > 2) ? $clog2(DATA_WIDTH) : 1;

  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
  localparam logic [SW-1:0] S_HALF    = SW'(OVERSAMPLE / 2 - 1);
  localparam logic [SW-1:0] S_LAST    = SW'(OVERSAMPLE - 1);
  localparam logic [NW-1:0] N_LAST    = NW'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_RX_PARITY_EN
    PARITY,
`endif
    STOP
  } state_t;

  state_t                state_q, state_d;
  logic                  rx_meta, rxs;
  logic [TW-1:0]         tick_cnt;
  logic                  tick;
  logic [SW-1:0]         s_q, s_d;
  logic [NW-1:0]         n_q, n_d;
  logic [DATA_WIDTH-1:0] sr_q, sr_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  done_q, done_d;
  logic                  ferr_q, ferr_d;
`ifdef UART_RX_PARITY_EN
  logic                  perr_lat_q, perr_lat_d;
  logic                  perr_q, perr_d;
`endif

  // Synchronizer flops reset to the idle (high) line level.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      rx_meta <= 1'b1;
      rxs     <= 1'b1;
    end else begin
      rx_meta <= bus.i_rx;
      rxs     <= rx_meta;
    end
  end

  // Free-running; deliberately not re-aligned to the start edge.
  always_ff @(posedge i_clock) begin
    if (i_reset || tick) tick_cnt <= '0;
    else                 tick_cnt <= tick_cnt + 1'b1;
  end
  assign tick = (tick_cnt == TICK_LAST);

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state_q    <= IDLE;
      s_q        <= '0;
      n_q        <= '0;
      sr_q       <= '0;
      data_q     <= '0;
      done_q     <= 1'b0;
      ferr_q     <= 1'b0;
`ifdef UART_RX_PARITY_EN
      perr_lat_q <= 1'b0;
      perr_q     <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      s_q        <= s_d;
      n_q        <= n_d;
      sr_q       <= sr_d;
      data_q     <= data_d;
      done_q     <= done_d;
      ferr_q     <= ferr_d;
`ifdef UART_RX_PARITY_EN
      perr_lat_q <= perr_lat_d;
      perr_q     <= perr_d;
`endif
    end
  end

  always_comb begin
    state_d    = state_q;
    s_d        = s_q;
    n_d        = n_q;
    sr_d       = sr_q;
    data_d     = data_q;
    done_d     = 1'b0;
    ferr_d     = 1'b0;
`ifdef UART_RX_PARITY_EN
    perr_lat_d = perr_lat_q;
    perr_d     = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (!rxs) begin
          state_d = START;
          s_d     = '0;
        end
      end
      START: begin
        if (tick) begin
          if (s_q == S_HALF) begin
            // A start bit that is high again at mid-bit was a glitch.
            state_d = rxs ? IDLE : DATA;
            s_d     = '0;
            n_d     = '0;
`ifdef UART_RX_PARITY_EN
            perr_lat_d = 1'b0;
`endif
          end else begin
            s_d = s_q + 1'b1;
          end
        end
      end
      DATA: begin
        if (tick) begin
          if (s_q == S_LAST) begin
            sr_d = {rxs, sr_q[DATA_WIDTH-1:1]};
            s_d  = '0;
            if (n_q == N_LAST) begin
`ifdef UART_RX_PARITY_EN
              state_d = PARITY;
`else
              state_d = STOP;
`endif
            end else begin
              n_d = n_q + 1'b1;
            end
          end else begin
            s_d = s_q + 1'b1;
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (tick) begin
          if (s_q == S_LAST) begin
            perr_lat_d = ^{sr_q, rxs};
            s_d        = '0;
            state_d    = STOP;
          end else begin
            s_d = s_q + 1'b1;
          end
        end
      end
`endif
      STOP: begin
        if (tick) begin
          if (s_q == S_LAST) begin
            // Leaving at mid stop bit lets an immediately following start bit be seen.
            state_d = IDLE;
            s_d     = '0;
            if (!rxs) begin
              ferr_d = 1'b1;
`ifdef UART_RX_PARITY_EN
            end else if (perr_lat_q) begin
              perr_d = 1'b1;
`endif
            end else begin
              done_d = 1'b1;
              data_d = sr_q;
            end
          end else begin
            s_d = s_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.o_data      = data_q;
  assign bus.o_done      = done_q;
  assign bus.o_frame_err = ferr_q;
`ifdef UART_RX_PARITY_EN
  assign bus.o_parity_err = perr_q;
`else
  assign bus.o_parity_err = 1'b0;
`endif

endmodule
